// File: rtl/i2c_mag_target_pkg.sv
// Shared constants for the magnetometer I2C target: register map, reset values,
// ID bytes, FSM encoding and the pointer auto-increment rule.
package i2c_mag_target_pkg;

    localparam logic [7:0] REG_CFG_A   = 8'h00;
    localparam logic [7:0] REG_CFG_B   = 8'h01;
    localparam logic [7:0] REG_MODE    = 8'h02;
    localparam logic [7:0] REG_DATA_XH = 8'h03;
    localparam logic [7:0] REG_DATA_XL = 8'h04;
    localparam logic [7:0] REG_DATA_ZH = 8'h05;
    localparam logic [7:0] REG_DATA_ZL = 8'h06;
    localparam logic [7:0] REG_DATA_YH = 8'h07;
    localparam logic [7:0] REG_DATA_YL = 8'h08;
    localparam logic [7:0] REG_STATUS  = 8'h09;
    localparam logic [7:0] REG_ID_A    = 8'h0A;
    localparam logic [7:0] REG_ID_B    = 8'h0B;
    localparam logic [7:0] REG_ID_C    = 8'h0C;

    localparam logic [7:0] CFG_A_RST = 8'h70;
    localparam logic [7:0] CFG_B_RST = 8'h20;
    localparam logic [7:0] MODE_RST  = 8'h01;

    localparam logic [7:0] ID_A = 8'h48;
    localparam logic [7:0] ID_B = 8'h34;
    localparam logic [7:0] ID_C = 8'h33;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_ADDR     = 4'd1,
        ST_ADDR_ACK = 4'd2,
        ST_PTR      = 4'd3,
        ST_PTR_ACK  = 4'd4,
        ST_WR_BYTE  = 4'd5,
        ST_WR_ACK   = 4'd6,
        ST_RD_BYTE  = 4'd7,
        ST_RD_ACK   = 4'd8
    } state_t;

    // Data registers wrap within themselves so a master can poll X/Z/Y forever.
    function automatic logic [7:0] next_ptr(input logic [7:0] p);
        if (p == REG_DATA_YL)
            return REG_DATA_XH;
        else if (p == REG_ID_C)
            return REG_CFG_A;
        else
            return p + 8'd1;
    endfunction

endpackage

// File: rtl/i2c_bus_cond.sv
// Synchronises the raw SCL/SDA lines and produces single-cycle pulses for SCL
// edges and START/STOP conditions.
module i2c_bus_cond #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic scl,
    input  logic sda_i,
    output logic sda_s,
    output logic scl_rise,
    output logic scl_fall,
    output logic start,
    output logic stop
);

    logic [SYNC_STAGES-1:0] scl_sync;
    logic [SYNC_STAGES-1:0] sda_sync;
    logic                   scl_prev;
    logic                   sda_prev;
    logic                   scl_now;

    // Idle bus is high on both lines, so reset there to avoid a phantom edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_prev <= 1'b1;
            sda_prev <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_i};
            scl_prev <= scl_sync[SYNC_STAGES-1];
            sda_prev <= sda_sync[SYNC_STAGES-1];
        end
    end

    assign scl_now  = scl_sync[SYNC_STAGES-1];
    assign sda_s    = sda_sync[SYNC_STAGES-1];
    assign scl_rise = scl_now & ~scl_prev;
    assign scl_fall = ~scl_now & scl_prev;
    assign start    = scl_now & scl_prev & sda_prev & ~sda_s;
    assign stop     = scl_now & scl_prev & ~sda_prev & sda_s;

endmodule

// File: rtl/i2c_mag_target.sv
// I2C target emulating a 3-axis magnetometer: config registers, coherent
// 6-byte data reads via a shadow snapshot, status and ID registers.
module i2c_mag_target
    import i2c_mag_target_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR    = 7'h1E,
    parameter int         SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        scl,
    input  logic        sda_i,
    output logic        sda_oe,
    input  logic [47:0] meas_data,
    input  logic        meas_load,
    output logic [7:0]  cfg_a,
    output logic [7:0]  cfg_b,
    output logic [7:0]  mode,
    output logic        busy,
    output logic [3:0]  dbg_state
);

    logic        sda_s;
    logic        scl_rise;
    logic        scl_fall;
    logic        start_det;
    logic        stop_det;

    state_t      state;
    logic [3:0]  bit_cnt;
    logic [6:0]  shift_r;
    logic [7:0]  ptr;
    logic        rw;
    logic [47:0] data_live;
    logic [47:0] data_shadow;
    logic        rdy;
    logic        rdy_shadow;
    logic [7:0]  rx_byte;
    logic [7:0]  rd_byte;
    logic        rd_bit;

    i2c_bus_cond #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_bus_cond (
        .clk      (clk),
        .rst      (rst),
        .scl      (scl),
        .sda_i    (sda_i),
        .sda_s    (sda_s),
        .scl_rise (scl_rise),
        .scl_fall (scl_fall),
        .start    (start_det),
        .stop     (stop_det)
    );

    assign dbg_state = state;
    assign rx_byte   = {shift_r, sda_s};

    // Data and status always come from the shadow so a multi-byte read is coherent.
    always_comb begin
        rd_byte = 8'h00;
        case (ptr)
            REG_CFG_A:   rd_byte = cfg_a;
            REG_CFG_B:   rd_byte = cfg_b;
            REG_MODE:    rd_byte = mode;
            REG_DATA_XH: rd_byte = data_shadow[47:40];
            REG_DATA_XL: rd_byte = data_shadow[39:32];
            REG_DATA_ZH: rd_byte = data_shadow[31:24];
            REG_DATA_ZL: rd_byte = data_shadow[23:16];
            REG_DATA_YH: rd_byte = data_shadow[15:8];
            REG_DATA_YL: rd_byte = data_shadow[7:0];
            REG_STATUS:  rd_byte = {7'b0, rdy_shadow};
            REG_ID_A:    rd_byte = ID_A;
            REG_ID_B:    rd_byte = ID_B;
            REG_ID_C:    rd_byte = ID_C;
            default:     rd_byte = 8'h00;
        endcase
    end

    assign rd_bit = rd_byte[3'd7 - bit_cnt[2:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            bit_cnt     <= '0;
            shift_r     <= '0;
            ptr         <= '0;
            rw          <= 1'b0;
            sda_oe      <= 1'b0;
            busy        <= 1'b0;
            cfg_a       <= CFG_A_RST;
            cfg_b       <= CFG_B_RST;
            mode        <= MODE_RST;
            data_live   <= '0;
            data_shadow <= '0;
            rdy         <= 1'b0;
            rdy_shadow  <= 1'b0;
        end else begin
            if (meas_load) begin
                data_live <= meas_data;
                rdy       <= 1'b1;
            end

            if (start_det || stop_det) begin
                state   <= start_det ? ST_ADDR : ST_IDLE;
                bit_cnt <= '0;
                sda_oe  <= 1'b0;
                busy    <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: ;

                    ST_ADDR, ST_PTR, ST_WR_BYTE: begin
                        if (scl_rise && bit_cnt < 4'd8) begin
                            shift_r <= rx_byte[6:0];
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                        if (scl_rise && bit_cnt == 4'd7) begin
                            if (state == ST_ADDR) begin
                                if (rx_byte[7:1] == DEV_ADDR) begin
                                    busy <= 1'b1;
                                    rw   <= rx_byte[0];
                                    if (rx_byte[0]) begin
                                        // A same-cycle sample wins: the reader gets it, RDY ends cleared.
                                        data_shadow <= meas_load ? meas_data : data_live;
                                        rdy_shadow  <= meas_load | rdy;
                                        rdy         <= 1'b0;
                                    end
                                end else begin
                                    state <= ST_IDLE;
                                end
                            end else if (state == ST_PTR) begin
                                ptr <= rx_byte;
                            end else begin
                                case (ptr)
                                    REG_CFG_A: cfg_a <= rx_byte;
                                    REG_CFG_B: cfg_b <= rx_byte;
                                    REG_MODE:  mode  <= rx_byte;
                                    default: ;
                                endcase
                                ptr <= next_ptr(ptr);
                            end
                        end
                        if (scl_fall && bit_cnt == 4'd8) begin
                            sda_oe <= 1'b1;
                            if (state == ST_ADDR)
                                state <= ST_ADDR_ACK;
                            else if (state == ST_PTR)
                                state <= ST_PTR_ACK;
                            else
                                state <= ST_WR_ACK;
                        end
                    end

                    ST_ADDR_ACK: begin
                        if (scl_fall) begin
                            bit_cnt <= '0;
                            if (rw) begin
                                state  <= ST_RD_BYTE;
                                sda_oe <= ~rd_byte[7];
                            end else begin
                                state  <= ST_PTR;
                                sda_oe <= 1'b0;
                            end
                        end
                    end

                    ST_PTR_ACK, ST_WR_ACK: begin
                        if (scl_fall) begin
                            state   <= ST_WR_BYTE;
                            bit_cnt <= '0;
                            sda_oe  <= 1'b0;
                        end
                    end

                    ST_RD_BYTE: begin
                        if (scl_rise)
                            bit_cnt <= bit_cnt + 4'd1;
                        if (scl_fall) begin
                            if (bit_cnt == 4'd8) begin
                                sda_oe  <= 1'b0;
                                state   <= ST_RD_ACK;
                                bit_cnt <= '0;
                            end else begin
                                sda_oe <= ~rd_bit;
                            end
                        end
                    end

                    // bit_cnt marks that the master's ACK has been seen this slot.
                    ST_RD_ACK: begin
                        if (scl_rise) begin
                            if (!sda_s) begin
                                ptr     <= next_ptr(ptr);
                                bit_cnt <= 4'd1;
                            end else begin
                                state <= ST_IDLE;
                            end
                        end
                        if (scl_fall && bit_cnt != 4'd0) begin
                            state   <= ST_RD_BYTE;
                            bit_cnt <= '0;
                            sda_oe  <= ~rd_byte[7];
                        end
                    end

                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule
